// File: rtl/rect_layer_renderer.sv
`default_nettype none
// ============================================================================
// Module   : rect_layer_renderer
// Function : NUM_RECTS programmable rectangle slots composited over an
//            incoming ARGB pixel stream. The lowest-index hit slot wins and
//            is drawn opaque or alpha-blended. Two register stages, no
//            backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module rect_layer_renderer #(
  parameter int NUM_RECTS = 4,
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 12,
  parameter int SLOT_W    = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_en,
  input  logic               prog_clear,
  input  logic [SLOT_W-1:0]  prog_slot,
  input  logic               prog_enable,
  input  logic               prog_blend,
  input  logic [X_WIDTH-1:0] prog_x,
  input  logic [Y_WIDTH-1:0] prog_y,
  input  logic [X_WIDTH-1:0] prog_width,
  input  logic [Y_WIDTH-1:0] prog_height,
  input  logic [31:0]        prog_color,
  input  logic               in_valid,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic [31:0]        color_in,
  output logic               out_valid,
  output logic [X_WIDTH-1:0] x_out,
  output logic [Y_WIDTH-1:0] y_out,
  output logic [31:0]        color_out
);

  // Per-slot results exported from the slot generate loop
  logic [NUM_RECTS-1:0] w_hit;
  logic [NUM_RECTS-1:0] w_blend;
  logic [31:0]          w_col [NUM_RECTS];

  // Priority-selected slot for the current input pixel
  logic        w_any;
  logic        w_sel_blend;
  logic [31:0] w_sel_fg;

  // Stage 1 registers
  logic               r1_valid;
  logic [X_WIDTH-1:0] r1_x;
  logic [Y_WIDTH-1:0] r1_y;
  logic [31:0]        r1_bg;
  logic               r1_hit;
  logic               r1_blend;
  logic [31:0]        r1_fg;

  // Stage 2 registers
  logic               r2_valid;
  logic [X_WIDTH-1:0] r2_x;
  logic [Y_WIDTH-1:0] r2_y;
  logic [31:0]        r2_color;

  // Composite result feeding stage 2
  logic [7:0]  w_alpha;
  logic [7:0]  w_inv_alpha;
  logic [31:0] w_comp;

  // One blended channel: (a*f + (256-a)*b) >> 8. Only called for a in 1..254,
  // so 256-a fits in 8 bits and the 17-bit sum never exceeds 16 bits.
  function automatic logic [7:0] blend_ch(input logic [7:0] a,
                                          input logic [7:0] inv_a,
                                          input logic [7:0] f,
                                          input logic [7:0] b);
    logic [15:0] p_f;
    logic [15:0] p_b;
    logic [16:0] s;
    p_f = {8'h00, a} * {8'h00, f};
    p_b = {8'h00, inv_a} * {8'h00, b};
    s   = {1'b0, p_f} + {1'b0, p_b};
    return s[15:8];
  endfunction

  genvar k;
  generate
    for (k = 0; k < NUM_RECTS; k++) begin : g_slot
      logic               r_en;
      logic               r_bl;
      logic [X_WIDTH-1:0] r_x0;
      logic [Y_WIDTH-1:0] r_y0;
      logic [X_WIDTH-1:0] r_w;
      logic [Y_WIDTH-1:0] r_h;
      logic [31:0]        r_col;
      logic               w_wr;
      logic [X_WIDTH:0]   w_xend;
      logic [Y_WIDTH:0]   w_yend;

      // Out-of-range slot numbers match no k and are therefore dropped
      assign w_wr   = prog_en && (prog_slot == SLOT_W'(k));
      // One extra bit so origin + size can never wrap
      assign w_xend = {1'b0, r_x0} + {1'b0, r_w};
      assign w_yend = {1'b0, r_y0} + {1'b0, r_h};

      assign w_hit[k]   = r_en && (x >= r_x0) && ({1'b0, x} < w_xend)
                               && (y >= r_y0) && ({1'b0, y} < w_yend);
      assign w_blend[k] = r_bl;
      assign w_col[k]   = r_col;

      // Slot storage: a write to this slot overrides a same-cycle clear
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_en  <= 1'b0;
          r_bl  <= 1'b0;
          r_x0  <= '0;
          r_y0  <= '0;
          r_w   <= '0;
          r_h   <= '0;
          r_col <= 32'h0;
        end else if (w_wr) begin
          r_en  <= prog_enable;
          r_bl  <= prog_blend;
          r_x0  <= prog_x;
          r_y0  <= prog_y;
          r_w   <= prog_width;
          r_h   <= prog_height;
          r_col <= prog_color;
        end else if (prog_clear) begin
          r_en  <= 1'b0;
        end
      end
    end
  endgenerate

  // Lowest-index hit wins: scan from the top so slot 0 is applied last
  always_comb begin
    w_any       = 1'b0;
    w_sel_blend = 1'b0;
    w_sel_fg    = 32'h0;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any       = 1'b1;
        w_sel_blend = w_blend[i];
        w_sel_fg    = w_col[i];
      end
    end
  end

  // Stage 1: latch the pixel and the winning slot's attributes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_x     <= '0;
      r1_y     <= '0;
      r1_bg    <= 32'h0;
      r1_hit   <= 1'b0;
      r1_blend <= 1'b0;
      r1_fg    <= 32'h0;
    end else begin
      r1_valid <= in_valid;
      r1_x     <= x;
      r1_y     <= y;
      r1_bg    <= color_in;
      r1_hit   <= w_any;
      r1_blend <= w_sel_blend;
      r1_fg    <= w_sel_fg;
    end
  end

  assign w_alpha     = r1_fg[31:24];
  assign w_inv_alpha = ~w_alpha + 8'd1;

  // Composite: pass-through, opaque, or blend with alpha extremes short-cut
  always_comb begin
    w_comp = r1_bg;
    if (r1_hit) begin
      if (!r1_blend || (w_alpha == 8'hFF)) begin
        w_comp = r1_fg;
      end else if (w_alpha == 8'h00) begin
        w_comp = r1_bg;
      end else begin
        w_comp = {8'hFF,
                  blend_ch(w_alpha, w_inv_alpha, r1_fg[23:16], r1_bg[23:16]),
                  blend_ch(w_alpha, w_inv_alpha, r1_fg[15:8],  r1_bg[15:8]),
                  blend_ch(w_alpha, w_inv_alpha, r1_fg[7:0],   r1_bg[7:0])};
      end
    end
  end

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_x     <= '0;
      r2_y     <= '0;
      r2_color <= 32'h0;
    end else begin
      r2_valid <= r1_valid;
      r2_x     <= r1_x;
      r2_y     <= r1_y;
      r2_color <= w_comp;
    end
  end

  assign out_valid = r2_valid;
  assign x_out     = r2_x;
  assign y_out     = r2_y;
  assign color_out = r2_color;

endmodule
`default_nettype wire

// File: tb/tb_rect_layer_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_layer_renderer
// Function : Self-checking bench for rect_layer_renderer: directed scenarios
//            with literal expectations plus a randomized stream compared
//            every cycle against a behavioural compositing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_layer_renderer;

  localparam int N  = 4;
  localparam int XW = 11;
  localparam int YW = 12;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_en, prog_clear, prog_enable, prog_blend;
  logic [SW-1:0] prog_slot;
  logic [XW-1:0] prog_x, prog_width;
  logic [YW-1:0] prog_y, prog_height;
  logic [31:0]   prog_color;
  logic          in_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [31:0]   color_in;
  logic          out_valid;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [31:0]   color_out;

  always #5 clk = ~clk;

  rect_layer_renderer #(.NUM_RECTS(N), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_en(prog_en), .prog_clear(prog_clear), .prog_slot(prog_slot),
    .prog_enable(prog_enable), .prog_blend(prog_blend),
    .prog_x(prog_x), .prog_y(prog_y), .prog_width(prog_width),
    .prog_height(prog_height), .prog_color(prog_color),
    .in_valid(in_valid), .x(x), .y(y), .color_in(color_in),
    .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .color_out(color_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit en; bit bl; int x0; int y0; int w; int h; logic [31:0] c; } slot_t;
  typedef struct { bit v; int x; int y; logic [31:0] c; } pix_t;

  slot_t ms [N];
  pix_t  m1, m2;

  function automatic logic [31:0] ref_color(input int px, input int py, input logic [31:0] bg);
    logic [31:0] fg, r;
    int a, f, b;
    for (int k = 0; k < N; k++) begin
      if (ms[k].en && px >= ms[k].x0 && px < ms[k].x0 + ms[k].w &&
          py >= ms[k].y0 && py < ms[k].y0 + ms[k].h) begin
        fg = ms[k].c;
        if (!ms[k].bl) return fg;
        a = int'(fg[31:24]);
        if (a == 255) return fg;
        if (a == 0) return bg;
        r = 32'hFF00_0000;
        for (int ch = 0; ch < 3; ch++) begin
          f = int'(fg[8*ch +: 8]);
          b = int'(bg[8*ch +: 8]);
          r[8*ch +: 8] = 8'((a * f + (256 - a) * b) / 256);
        end
        return r;
      end
    end
    return bg;
  endfunction

  // Model: pixel sees slot contents from before this edge's programming
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) ms[k] <= '{1'b0, 1'b0, 0, 0, 0, 0, 32'h0};
      m1 <= '{1'b0, 0, 0, 32'h0};
      m2 <= '{1'b0, 0, 0, 32'h0};
    end else begin
      m2 <= m1;
      m1 <= '{in_valid, int'(x), int'(y), ref_color(int'(x), int'(y), color_in)};
      if (prog_clear)
        for (int k = 0; k < N; k++) ms[k].en <= 1'b0;
      if (prog_en && int'(prog_slot) < N)
        ms[prog_slot] <= '{prog_enable, prog_blend, int'(prog_x), int'(prog_y),
                           int'(prog_width), int'(prog_height), prog_color};
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", 32'(out_valid), 32'(m2.v));
      if (m2.v) begin
        chk("x_out", 32'(x_out), m2.x);
        chk("y_out", 32'(y_out), m2.y);
        chk("color_out", color_out, m2.c);
      end
    end
  end

  // ---------------- stimulus helpers (start and end at negedge) ----------------
  task automatic prog(input int s, input bit en, input bit bl, input int x0, input int y0,
                      input int w, input int h, input logic [31:0] c, input bit clr);
    prog_en = 1'b1; prog_clear = clr; prog_slot = SW'(s);
    prog_enable = en; prog_blend = bl;
    prog_x = XW'(x0); prog_y = YW'(y0); prog_width = XW'(w); prog_height = YW'(h);
    prog_color = c;
    @(negedge clk);
    prog_en = 1'b0; prog_clear = 1'b0;
  endtask

  task automatic clear_all();
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
  endtask

  task automatic pix(input int px, input int py, input logic [31:0] bg);
    in_valid = 1'b1; x = XW'(px); y = YW'(py); color_in = bg;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pix_check(input string nm, input int px, input int py,
                           input logic [31:0] bg, input logic [31:0] exp);
    pix(px, py, bg);
    @(negedge clk);
    chk(nm, color_out, exp);
  endtask

  localparam logic [31:0] BG    = 32'hFF0000FF;
  localparam logic [31:0] RED   = 32'hFFFF0000;
  localparam logic [31:0] GREEN = 32'hFF00FF00;

  initial begin
    rst_n = 1'b0; prog_en = 1'b0; prog_clear = 1'b0; prog_slot = '0;
    prog_enable = 1'b0; prog_blend = 1'b0; prog_x = '0; prog_y = '0;
    prog_width = '0; prog_height = '0; prog_color = 32'h0;
    in_valid = 1'b0; x = '0; y = '0; color_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_x", 32'(x_out), 32'h0);
    chk("reset_y", 32'(y_out), 32'h0);
    chk("reset_color", color_out, 32'h0);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Full-screen opaque over a 135-step grid
    prog(0, 1, 0, 0, 0, 1080, 2160, 32'hFF000000, 0);
    for (int yy = 0; yy < 2160; yy += 135)
      for (int xx = 0; xx < 1080; xx += 135) begin
        in_valid = 1'b1; x = XW'(xx); y = YW'(yy); color_in = BG;
        @(negedge clk);
      end
    in_valid = 1'b0;
    pix_check("full_corner", 1079, 2159, BG, 32'hFF000000);

    // Width boundary, then shifted origin
    prog(0, 1, 0, 0, 0, 540, 2160, RED, 0);
    pix_check("w_539_in", 539, 10, BG, RED);
    pix_check("w_540_out", 540, 10, BG, BG);
    prog(0, 1, 0, 540, 0, 540, 2160, RED, 0);
    pix_check("s_539_out", 539, 10, BG, BG);
    pix_check("s_540_in", 540, 10, BG, RED);
    pix_check("s_1079_in", 1079, 10, BG, RED);

    // Priority, clear, clear+write
    prog(1, 1, 0, 0, 0, 1080, 2160, GREEN, 0);
    prog(0, 1, 0, 0, 0, 100, 100, RED, 0);
    pix_check("prio_slot0", 50, 50, BG, RED);
    pix_check("prio_slot1", 200, 200, BG, GREEN);
    clear_all();
    pix_check("clear_bg", 50, 50, BG, BG);
    prog(0, 1, 0, 0, 0, 100, 100, RED, 0);
    prog(1, 1, 0, 0, 0, 1080, 2160, GREEN, 0);
    prog(2, 1, 0, 0, 0, 1080, 2160, 32'hFF123456, 1);
    pix_check("clrwr_slot2", 50, 50, BG, 32'hFF123456);
    pix_check("clrwr_slot2b", 500, 500, BG, 32'hFF123456);

    // Alpha blend
    clear_all();
    prog(0, 1, 1, 0, 0, 1080, 2160, 32'h80FF0000, 0);
    pix_check("blend_80", 10, 10, BG, 32'hFF7F007F);
    prog(0, 1, 1, 0, 0, 1080, 2160, 32'hFFFF0000, 0);
    pix_check("blend_ff", 10, 10, BG, 32'hFFFF0000);
    prog(0, 1, 1, 0, 0, 1080, 2160, 32'h00FF0000, 0);
    pix_check("blend_00", 10, 10, BG, BG);
    pix_check("blend_00_bgA", 10, 10, 32'h12345678, 32'h12345678);

    // Program ordering: write and pixel P on the same edge
    prog(0, 1, 0, 0, 0, 1080, 2160, GREEN, 0);
    prog_en = 1'b1; prog_clear = 1'b0; prog_slot = '0; prog_enable = 1'b1; prog_blend = 1'b0;
    prog_x = '0; prog_y = '0; prog_width = XW'(1080); prog_height = YW'(2160); prog_color = RED;
    in_valid = 1'b1; x = XW'(5); y = YW'(5); color_in = BG;
    @(negedge clk);
    prog_en = 1'b0; x = XW'(6);
    @(negedge clk);
    in_valid = 1'b0;
    chk("order_old", color_out, GREEN);
    @(negedge clk);
    chk("order_new", color_out, RED);

    // No-wrap of origin + size
    prog(0, 1, 0, 1000, 0, 200, 2160, RED, 0);
    pix_check("nw_1079_in", 1079, 3, BG, RED);
    pix_check("nw_999_out", 999, 3, BG, BG);
    prog(0, 1, 0, 2000, 0, 100, 2160, RED, 0);
    pix_check("nw_2040_in", 2040, 3, BG, RED);
    pix_check("nw_2047_in", 2047, 3, BG, RED);
    pix_check("nw_1999_out", 1999, 3, BG, BG);

    // Randomized stream with concurrent programming
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      prog_en     = ($urandom_range(0, 7) == 0);
      prog_clear  = ($urandom_range(0, 31) == 0);
      prog_slot   = SW'($urandom);
      prog_enable = ($urandom_range(0, 3) != 0);
      prog_blend  = 1'($urandom);
      prog_x      = XW'($urandom_range(0, 900));
      prog_y      = YW'($urandom_range(0, 900));
      prog_width  = XW'($urandom_range(0, 400));
      prog_height = YW'($urandom_range(0, 400));
      prog_color  = {a, 24'($urandom)};
      in_valid    = 1'($urandom);
      x           = XW'($urandom_range(0, 1300));
      y           = YW'($urandom_range(0, 1300));
      color_in    = $urandom;
      @(negedge clk);
    end
    prog_en = 1'b0; prog_clear = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-stream, with a write attempted during reset
    prog(0, 1, 0, 0, 0, 1080, 2160, RED, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; x = XW'(i * 10); y = YW'(i); color_in = $urandom;
      rst_n   = (i != 4);
      prog_en = (i == 4); prog_slot = SW'(1); prog_enable = 1'b1; prog_blend = 1'b0;
      prog_x = '0; prog_y = '0; prog_width = XW'(1080); prog_height = YW'(2160);
      prog_color = GREEN;
      @(negedge clk);
      if (i == 4) begin
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_x", 32'(x_out), 32'h0);
        chk("rst_mid_y", 32'(y_out), 32'h0);
        chk("rst_mid_color", color_out, 32'h0);
      end
    end
    prog_en = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    pix_check("post_rst_bg", 50, 50, 32'h11223344, 32'h11223344);
    pix_check("post_rst_bg2", 900, 1500, BG, BG);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
